pll_phase_ctrl: RTL and testbench

//   Run-time supervisor and dynamic phase stepper for an ECP5 EHXPLLL.
//   - Holds the PLL in reset at start-up, then qualifies LOCK.
//   - Accepts signed phase-step requests per output channel and drives the

---
 rtl/pll_phase_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL supervisor: holds the PLL in reset, qualifies LOCK, then steps per-channel phase on request.
// Request-to-ready latency is 1 + SETUP + |n|*(PULSE+GAP) cycles; req_ready is low while stepping or unlocked.
module pll_phase_ctrl #(
    parameter int NUM_CH          = 4,
    parameter int STEP_W          = 8,
    parameter int STEPS_PER_CYCLE = 104,
    parameter int PH_W            = 7,
    parameter int SETUP_CYCLES    = 2,
    parameter int PULSE_CYCLES    = 4,
    parameter int GAP_CYCLES      = 4,
    parameter int RST_CYCLES      = 16,
    parameter int LOCK_FILTER     = 1024
) (
    input  logic                     clkin,
    input  logic                     resetn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_ch,
    input  logic signed [STEP_W-1:0] req_steps,
    output logic                     busy,
    input  logic [1:0]               rd_ch,
    output logic [PH_W-1:0]          rd_phase,
    input  logic                     pll_locked,
    output logic                     locked,
    output logic [7:0]               relock_cnt,
    output logic                     pll_rst,
    output logic [1:0]               pll_phasesel,
    output logic                     pll_phasedir,
    output logic                     pll_phasestep
);

    localparam int MAX_LONG  = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES : LOCK_FILTER;
    localparam int MAX_SHORT = (SETUP_CYCLES > PULSE_CYCLES) ?
                               ((SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES) :
                               ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES);
    localparam int CNT_MAX   = (MAX_LONG > MAX_SHORT) ? MAX_LONG : MAX_SHORT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_IDLE,
        S_SKIP,
        S_SETUP,
        S_PULSE,
        S_GAP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [STEP_W-1:0]   remaining;
    logic [STEP_W-1:0]   rem_nxt;
    logic                lock_meta;
    logic                lock_s;
    logic [PH_W-1:0]     phase [NUM_CH];

    logic                accept;
    logic                req_ok;
    logic                lock_lost;
    logic                step_taken;
    logic [STEP_W-1:0]   req_mag;

    // Two's-complement magnitude; the most negative value maps to 2^(STEP_W-1) as unsigned.
    assign req_mag    = req_steps[STEP_W-1] ? ((~req_steps) + STEP_W'(1)) : req_steps;
    assign req_ok     = (int'(req_ch) < NUM_CH) && (req_steps != '0);
    assign req_ready  = (state == S_IDLE) && lock_s;
    assign accept     = req_valid && req_ready;
    assign busy       = (state != S_IDLE);
    assign lock_lost  = !lock_s && (state != S_RESET_PLL) && (state != S_WAIT_LOCK);
    assign step_taken = (state == S_PULSE) && (state_nxt == S_GAP);

    always_ff @(posedge clkin) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rem_nxt   = remaining;
        unique case (state)
            S_RESET_PLL: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_W'(LOCK_FILTER - 1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    cnt_nxt = '0;
                    if (req_ok) begin
                        state_nxt = S_SETUP;
                        rem_nxt   = req_mag;
                    end else begin
                        state_nxt = S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                state_nxt = S_IDLE;
            end
            S_SETUP: begin
                if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
                    state_nxt = S_PULSE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                    rem_nxt   = remaining - 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_nxt = (remaining != '0) ? S_PULSE : S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_RESET_PLL;
                cnt_nxt   = '0;
            end
        endcase
        // Lock loss overrides everything, including a request presented in the same cycle.
        if (lock_lost) begin
            state_nxt = S_RESET_PLL;
            cnt_nxt   = '0;
            rem_nxt   = '0;
        end
    end

    always_ff @(posedge clkin) begin
        if (!resetn) begin
            state         <= S_RESET_PLL;
            cnt           <= '0;
            remaining     <= '0;
            pll_rst       <= 1'b1;
            pll_phasestep <= 1'b1;
            pll_phasesel  <= 2'd0;
            pll_phasedir  <= 1'b0;
            locked        <= 1'b0;
            relock_cnt    <= 8'd0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            remaining     <= rem_nxt;
            pll_rst       <= (state_nxt == S_RESET_PLL);
            pll_phasestep <= (state_nxt != S_PULSE);
            if (lock_lost) begin
                locked <= 1'b0;
                if (relock_cnt != 8'hFF) begin
                    relock_cnt <= relock_cnt + 8'd1;
                end
            end else if ((state == S_WAIT_LOCK) && (state_nxt == S_IDLE)) begin
                locked <= 1'b1;
            end
            if (accept && req_ok) begin
                pll_phasesel <= req_ch;
                pll_phasedir <= req_steps[STEP_W-1];
            end
        end
    end

    function automatic logic [PH_W-1:0] phase_step(input logic [PH_W-1:0] p, input logic dir);
        logic [PH_W-1:0] r;
        if (!dir) begin
            r = (p == PH_W'(STEPS_PER_CYCLE - 1)) ? '0 : p + 1'b1;
        end else begin
            r = (p == '0) ? PH_W'(STEPS_PER_CYCLE - 1) : p - 1'b1;
        end
        return r;
    endfunction

    always_ff @(posedge clkin) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                phase[i] <= '0;
            end
        end else if (lock_lost) begin
            for (int i = 0; i < NUM_CH; i++) begin
                phase[i] <= '0;
            end
        end else if (step_taken) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pll_phasesel == 2'(i)) begin
                    phase[i] <= phase_step(phase[i], pll_phasedir);
                end
            end
        end
    end

    // Looping over real channels makes out-of-range rd_ch read back as zero.
    always_comb begin
        rd_phase = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == 2'(i)) begin
                rd_phase = phase[i];
            end
        end
    end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: a 4-channel instance and a 2-channel instance share request stimulus,
// use_b selects which one receives req_valid and whose outputs are observed.
module tb_pll_phase_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn_a, resetn_b, lock_a, lock_b;
    logic              req_valid, use_b;
    logic [1:0]        req_ch, rd_ch;
    logic signed [7:0] req_steps;

    logic       rdy_a, busy_a, locked_a, rst_a, dir_a, step_a;
    logic       rdy_b, busy_b, locked_b, rst_b, dir_b, step_b;
    logic [6:0] ph_a, ph_b;
    logic [7:0] rl_a, rl_b;
    logic [1:0] sel_a, sel_b;
    logic       vld_a, vld_b;

    assign vld_a = req_valid & ~use_b;
    assign vld_b = req_valid & use_b;

    pll_phase_ctrl dut_a (
        .clkin(clk), .resetn(resetn_a), .req_valid(vld_a), .req_ready(rdy_a),
        .req_ch(req_ch), .req_steps(req_steps), .busy(busy_a), .rd_ch(rd_ch),
        .rd_phase(ph_a), .pll_locked(lock_a), .locked(locked_a), .relock_cnt(rl_a),
        .pll_rst(rst_a), .pll_phasesel(sel_a), .pll_phasedir(dir_a), .pll_phasestep(step_a)
    );

    pll_phase_ctrl #(.NUM_CH(2)) dut_b (
        .clkin(clk), .resetn(resetn_b), .req_valid(vld_b), .req_ready(rdy_b),
        .req_ch(req_ch), .req_steps(req_steps), .busy(busy_b), .rd_ch(rd_ch),
        .rd_phase(ph_b), .pll_locked(lock_b), .locked(locked_b), .relock_cnt(rl_b),
        .pll_rst(rst_b), .pll_phasesel(sel_b), .pll_phasedir(dir_b), .pll_phasestep(step_b)
    );

    logic       o_ready, o_busy, o_locked, o_rst, o_dir, o_step;
    logic [6:0] o_phase;
    logic [7:0] o_relock;
    logic [1:0] o_sel;
    assign o_ready  = use_b ? rdy_b    : rdy_a;
    assign o_busy   = use_b ? busy_b   : busy_a;
    assign o_locked = use_b ? locked_b : locked_a;
    assign o_rst    = use_b ? rst_b    : rst_a;
    assign o_dir    = use_b ? dir_b    : dir_a;
    assign o_step   = use_b ? step_b   : step_a;
    assign o_phase  = use_b ? ph_b     : ph_a;
    assign o_relock = use_b ? rl_b     : rl_a;
    assign o_sel    = use_b ? sel_b    : sel_a;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_pll_rst"}, o_rst, 1);
        check({pfx, "_locked"}, o_locked, 0);
        check({pfx, "_busy"}, o_busy, 1);
        check({pfx, "_relock"}, o_relock, 0);
        check({pfx, "_step"}, o_step, 1);
        check({pfx, "_sel"}, o_sel, 0);
        check({pfx, "_dir"}, o_dir, 0);
        check({pfx, "_ready"}, o_ready, 0);
    endtask

    // Issues one request at a negedge and samples every negedge until req_ready returns.
    task automatic run_req(input logic [1:0] ch, input logic signed [7:0] steps, input bit expect_steps,
                           output int lat, output int pulses, output int low_cyc,
                           output int busy_cyc, output int bad);
        logic exp_dir;
        logic prev;
        exp_dir = (steps < 0);
        check("ready_before_req", o_ready, 1);
        req_valid = 1'b1;
        req_ch    = ch;
        req_steps = steps;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; pulses = 0; low_cyc = 0; busy_cyc = 0; bad = 0; prev = 1'b1;
        while (!o_ready && lat < 3000) begin
            if (o_busy) busy_cyc++;
            if (!o_step) begin
                low_cyc++;
                if (prev) pulses++;
            end
            if (expect_steps && o_busy && (o_sel !== ch || o_dir !== exp_dir)) bad++;
            prev = o_step;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_pulse_start(input int n, output bit ok);
        int   seen;
        int   guard;
        logic prev;
        seen = 0; guard = 0; ok = 1'b0; prev = o_step;
        while (!ok && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (prev && !o_step) begin
                seen++;
                if (seen == n) ok = 1'b1;
            end
            prev = o_step;
        end
    endtask

    task automatic wait_locked(input string tag);
        int cnt;
        cnt = 0;
        while (!o_locked && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lock_latency_in_range"}, (cnt >= 1024 && cnt <= 1027), 1);
        check({tag, "_ready_at_lock"}, o_ready, 1);
        check({tag, "_busy_at_lock"}, o_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cnt, lat, pulses, low_cyc, busy_cyc, bad;
        bit  ok;
        resetn_a = 1'b0; resetn_b = 1'b0; lock_a = 1'b1; lock_b = 1'b1;
        req_valid = 1'b0; use_b = 1'b0; req_ch = 2'd0; req_steps = 8'sd0; rd_ch = 2'd0;

        // Start-up: reset values, pll_rst width, lock qualification.
        repeat (5) @(negedge clk);
        check_reset_vals("t1");
        check("t1_rd_phase", o_phase, 0);
        resetn_a = 1'b1;
        resetn_b = 1'b1;
        cnt = 0;
        while (o_rst && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("t1_pll_rst_len", cnt, 16);
        wait_locked("t1");
        use_b = 1'b1;
        #1;
        check("t1_b_locked", o_locked, 1);
        use_b = 1'b0;
        #1;

        // ch1 +3
        rd_ch = 2'd1;
        run_req(2'd1, 8'sd3, 1'b1, lat, pulses, low_cyc, busy_cyc, bad);
        check("t2_latency", lat, 27);
        check("t2_pulses", pulses, 3);
        check("t2_low_cycles", low_cyc, 12);
        check("t2_busy_cycles", busy_cyc, 26);
        check("t2_sel_dir_stable", bad, 0);
        check("t2_phase_ch1", o_phase, 3);

        // ch2 -1 wraps to 103, +1 wraps back to 0
        rd_ch = 2'd2;
        run_req(2'd2, -8'sd1, 1'b1, lat, pulses, low_cyc, busy_cyc, bad);
        check("t3_latency", lat, 11);
        check("t3_pulses", pulses, 1);
        check("t3_sel_dir_stable", bad, 0);
        check("t3_phase_wrap_down", o_phase, 103);
        run_req(2'd2, 8'sd1, 1'b1, lat, pulses, low_cyc, busy_cyc, bad);
        check("t3_phase_wrap_up", o_phase, 0);
        check("t3_sel_dir_stable2", bad, 0);
        rd_ch = 2'd1;
        #1;
        check("t3_ch1_untouched", o_phase, 3);

        // Two-channel instance: bad channel, zero steps, and the -128 extreme.
        use_b = 1'b1;
        rd_ch = 2'd0;
        #1;
        run_req(2'd3, 8'sd5, 1'b0, lat, pulses, low_cyc, busy_cyc, bad);
        check("t5_badch_pulses", pulses, 0);
        check("t5_badch_busy", busy_cyc, 1);
        check("t5_badch_latency", lat, 2);
        run_req(2'd0, 8'sd0, 1'b0, lat, pulses, low_cyc, busy_cyc, bad);
        check("t5_zero_pulses", pulses, 0);
        check("t5_zero_busy", busy_cyc, 1);
        check("t5_zero_phase", o_phase, 0);
        run_req(2'd0, -8'sd128, 1'b1, lat, pulses, low_cyc, busy_cyc, bad);
        check("t5_m128_pulses", pulses, 128);
        check("t5_m128_latency", lat, 1027);
        check("t5_m128_sel_dir_stable", bad, 0);
        check("t5_m128_phase", o_phase, 80);
        rd_ch = 2'd3;
        #1;
        check("t5_rd_out_of_range", o_phase, 0);
        use_b = 1'b0;
        #1;

        // ch0 +10 with lock dropped at the start of the fourth pulse.
        rd_ch = 2'd0;
        #1;
        check("t4_ready", o_ready, 1);
        req_valid = 1'b1; req_ch = 2'd0; req_steps = 8'sd10;
        @(negedge clk);
        req_valid = 1'b0;
        wait_pulse_start(4, ok);
        check("t4_reached_pulse4", ok, 1);
        check("t4_phase_before_loss", o_phase, 3);
        lock_a = 1'b0;
        cnt = 0;
        while (!o_step && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("t4_step_release_cycles", cnt, 3);
        check("t4_locked", o_locked, 0);
        check("t4_relock_cnt", o_relock, 1);
        check("t4_busy", o_busy, 1);
        check("t4_ready", o_ready, 0);
        check("t4_phase_ch0", o_phase, 0);
        rd_ch = 2'd1;
        #1;
        check("t4_phase_ch1", o_phase, 0);
        lock_a = 1'b1;
        cnt = 0;
        while (o_rst && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("t4_pll_rst_len", cnt, 16);
        wait_locked("t4");
        check("t4_relock_after", o_relock, 1);

        // Synchronous reset in the middle of a pulse.
        rd_ch = 2'd1;
        req_valid = 1'b1; req_ch = 2'd1; req_steps = 8'sd2;
        @(negedge clk);
        req_valid = 1'b0;
        wait_pulse_start(2, ok);
        check("t6_reached_pulse2", ok, 1);
        check("t6_phase_mid", o_phase, 1);
        check("t6_step_low", o_step, 0);
        resetn_a = 1'b0;
        @(negedge clk);
        check_reset_vals("t6");
        check("t6_phase_cleared", o_phase, 0);
        resetn_a = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
